// File: rtl/cpu_sequencer_if.sv
// Datapath-facing bundle of the multicycle sequencer: instruction fetch, PC/IR
// and the Moore-style control strobes consumed by the MIPS-subset datapath.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  // No valid/ready pair: every strobe is a level for the current cycle, owned
  // by the master (sequencer); instr/zero are combinational returns from the slave.
  logic [31:0]     instr;
  logic            zero;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            reg_write;
  logic            reg_dst;
  logic            ula_src;
  logic [2:0]      ula_control;
  logic            mem_write;
  logic            mem_to_reg;

  modport master (
    input  instr, zero,
    output pc, ir, reg_write, reg_dst, ula_src, ula_control, mem_write, mem_to_reg
  );

  modport slave (
    output instr, zero,
    input  pc, ir, reg_write, reg_dst, ula_src, ula_control, mem_write, mem_to_reg
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer owning PC and IR.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module cpu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  cpu_sequencer_if.master     bus,
  output logic [2:0]          state,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [15:0]         retired
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic            illegal_q;
  logic            eoi;

  logic [5:0] opcode, funct;
  logic       is_r, r_ok, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, legal;
  logic [2:0] r_alu;
  logic       in_ex;

  assign opcode  = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign is_r    = (opcode == 6'h00);
  assign is_addi = (opcode == 6'h08);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_j    = (opcode == 6'h02);
  assign is_halt = (opcode == 6'h3F);

  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'b010;
    case (funct)
      6'h20:   r_alu = 3'b010;
      6'h22:   r_alu = 3'b110;
      6'h24:   r_alu = 3'b000;
      6'h25:   r_alu = 3'b001;
      6'h2A:   r_alu = 3'b111;
      default: r_ok  = 1'b0;
    endcase
  end

  assign legal = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

  // eoi marks the end-of-instruction transition; HALT entry never counts.
  always_comb begin
    state_d = state_q;
    eoi     = 1'b0;
    case (state_q)
      S_IDLE:    if (run || step) state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt || !legal) state_d = S_HALT;
        else if (is_j)         eoi     = 1'b1;
        else                   state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_beq)              eoi     = 1'b1;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_WRITEBACK;
      end
      S_MEM: begin
        if (is_sw) eoi     = 1'b1;
        else       state_d = S_WRITEBACK;
      end
      S_WRITEBACK: eoi = 1'b1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
    if (eoi) state_d = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          ir_q <= bus.instr;
          pc_q <= pc_q + PC_W'(1);
        end
        S_DECODE: begin
          if (!is_halt && !legal) illegal_q <= 1'b1;
          else if (is_j && legal) pc_q      <= ir_q[PC_W-1:0];
        end
        // pc already points past the branch, so the offset is added to pc+1.
        S_EXECUTE: if (is_beq && bus.zero) pc_q <= pc_q + ir_q[PC_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     retired_q <= '0;
    else if (eoi) retired_q <= retired_q + 16'd1;
  end
  assign retired = retired_q;
`else
  assign retired = 16'd0;
`endif

  // Controls are decoded from the held IR, so MEM/WRITEBACK keep EXECUTE's values.
  assign in_ex = (state_q == S_EXECUTE) || (state_q == S_MEM) || (state_q == S_WRITEBACK);

  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.reg_dst     = in_ex && is_r;
  assign bus.ula_src     = in_ex && (is_addi || is_lw || is_sw);
  assign bus.ula_control = !in_ex ? 3'b000 : is_r ? r_alu : is_beq ? 3'b110 : 3'b010;
  assign bus.reg_write   = (state_q == S_WRITEBACK);
  assign bus.mem_write   = (state_q == S_MEM) && is_sw;
  assign bus.mem_to_reg  = (state_q == S_WRITEBACK) && is_lw;

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the 8-bit MIPS-subset datapath (InstrMemory, RegisterFile, ULA, ULASrc/RegDst muxes). It owns the PC and instruction register and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives the datapath's Moore-style control strobes, so a single-step key can walk the CPU one instruction at a time on the board. It replaces the combinational ControlUnit plus free-running PC in the top level.

## Interface
- PC_W, 8, PC and instruction-memory address width (word addressed)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-run, 0 = single-step mode
- step  in  1  one-cycle pulse (already synchronised/debounced); starts one instruction in step mode
- instr  in  32  instruction word from InstrMemory at address pc (combinational)
- zero  in  1  ULA Z flag
- pc  out  PC_W  program counter
- ir  out  32  latched instruction; fields ir[25:21], ir[20:16], ir[15:11] feed RegisterFile/MuxWR
- reg_write  out  1  RegisterFile we3
- reg_dst  out  1  MuxWR select (1 = rd, 0 = rt)
- ula_src  out  1  MuxULASrc select (1 = immediate)
- ula_control  out  3  ULA op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- mem_write  out  1  data-memory write strobe
- mem_to_reg  out  1  writeback select (1 = memory data)
- state  out  3  current state encoding, for LCD/debug
- busy  out  1  1 in any state other than IDLE/HALT
- halted  out  1  1 in HALT
- illegal  out  1  sticky; 1 if HALT entered by an undecodable instruction
- retired  out  16  retired-instruction count (only with SEQ_RETIRE_CNT_EN)

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, WRITEBACK 5, HALT 7.
- IDLE -> FETCH when run=1, or when step=1. run and step together: treated as run.
- FETCH: ir <= instr; pc <= pc+1 (wraps 2^PC_W-1 -> 0). -> DECODE.
- DECODE: opcode ir[31:26]. R-type 0x00 (funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02 -> EXECUTE. Opcode 0x3F -> HALT. Any other opcode or R-type funct -> HALT with illegal=1.
- j: resolved in DECODE: pc <= ir[PC_W-1:0]; -> end-of-instruction.
- EXECUTE: R-type: reg_dst=1, ula_src=0, ula_control from funct; addi/lw/sw: ula_src=1, ula_control=010; beq: ula_src=0, ula_control=110, and if zero=1 then pc <= pc + ir[PC_W-1:0] (pc already incremented, modulo 2^PC_W). R-type/addi -> WRITEBACK; lw/sw -> MEM; beq -> end-of-instruction.
- MEM: ula controls held; sw: mem_write=1 for this cycle, then end-of-instruction; lw -> WRITEBACK.
- WRITEBACK: reg_write=1 for exactly this cycle; reg_dst/ula_src/ula_control held from EXECUTE; mem_to_reg=1 for lw only. -> end-of-instruction.
- End-of-instruction: -> FETCH if run=1, else -> IDLE (step pulses arriving while busy are ignored).
- HALT: absorbing; only rst exits. All strobes 0.
- Outside the listed states every strobe is 0; reg_write and mem_write are never 1 in the same cycle.

## Timing
- Reset (async, immediate): state=IDLE, pc=0, ir=0, all strobes 0, busy=0, halted=0, illegal=0, retired=0.
- Cycles per instruction from FETCH entry: j 2, beq 3, sw 4, R-type/addi 4, lw 5.
- pc and ir update on the FETCH->DECODE edge; datapath register-file reads are valid from DECODE onward.
- Register write occurs on the clock edge ending WRITEBACK.
- rst asserted mid-instruction aborts it; no partial write is retained by the sequencer.

## Configuration
- SEQ_RETIRE_CNT_EN defined: retired increments by 1 at every end-of-instruction transition (not on HALT entry); wraps 0xFFFF -> 0.
- Undefined: retired port tied to 0; no counter flops.

## Test plan
- Reset then run=1, instr=0x00221820 (add r3,r1,r2) -> states 1,2,3,5,1; reg_write=1 only in state 5 with reg_dst=1, ula_control=010; pc 0 -> 1.
- run=0, one step pulse, addi 0x20010005 -> one instruction executed, back to IDLE, pc=1; second pulse while busy ignored.
- beq 0x10000003 at pc=4 with zero=1 -> pc=8 after EXECUTE; with zero=0 -> pc=5; 3 cycles each.
- j 0x080000FF at pc=0x10 -> pc=0xFF after DECODE; next FETCH at 0xFF wraps pc to 0x00.
- instr 0xFC000000 -> HALT, halted=1, illegal=0; instr 0x1C000000 -> HALT, illegal=1; run/step ignored until rst.
- SEQ_RETIRE_CNT_EN: run add, sw, lw, beq -> retired=4; assert rst mid-lw -> retired=0, pc=0, reg_write never pulsed.
